// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C write master.
// State encoding, quarter-bit phase codes, divider calculation.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    STOP,
    DONE
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // System clocks per quarter of an SCL period.
  function automatic int calc_div(
    input int clk_freq,
    input int i2c_freq
  );
    return clk_freq / (4 * i2c_freq);
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit clock-enable divider for the I2C write master.
// Ports: iCLK, iRST (sync high), iEN (run), oTICK (1 clk every DIV).
module i2c_tick_gen #(
  parameter int DIV = 625
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iEN,
  output logic oTICK
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(DIV - 1));
  assign oTICK  = iEN && w_last;

  // Held at zero while disabled so every transfer starts
  // with a full first quarter.
  always_ff @(posedge iCLK) begin
    if (iRST || !iEN) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_write_master.sv
// Write-only single-master I2C engine: START, NUM_BYTES bytes, STOP.
// Ports: iCLK, iRST, iDATA, iGO/oEND handshake, oACK (1=NACK seen),
//        I2C_SCLK push-pull, I2C_SDAT open-drain.
module i2c_write_master
  import i2c_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int I2C_FREQ  = 20000,
  parameter int NUM_BYTES = 3
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic [8*NUM_BYTES-1:0] iDATA,
  input  logic                   iGO,
  output logic                   oEND,
  output logic                   oACK,
  output logic                   I2C_SCLK,
  inout  wire                    I2C_SDAT
);

  localparam int DIV = calc_div(CLK_FREQ, I2C_FREQ);
  localparam int W   = 8 * NUM_BYTES;
  localparam int BW  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  state_t         r_state;
  logic [1:0]     r_q;
  logic [2:0]     r_bit;
  logic [BW-1:0]  r_byte;
  logic [W-1:0]   r_shift;
  logic           r_scl;
  logic           r_sda_low;
  logic           r_end;
  logic           r_ack;
  logic           w_tick;
  logic           w_en;
  logic           w_sda_in;
  logic           w_last_byte;

  assign w_en        = (r_state != IDLE);
  assign w_sda_in    = I2C_SDAT;
  assign w_last_byte = (r_byte == BW'(NUM_BYTES - 1));

  assign I2C_SDAT = r_sda_low ? 1'b0 : 1'bz;
  assign I2C_SCLK = r_scl;
  assign oEND     = r_end;
  assign oACK     = r_ack;

  i2c_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iEN   (w_en),
    .oTICK (w_tick)
  );

  // Each tick ends the current quarter; the bus levels of the
  // next quarter are loaded on that same edge.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state   <= IDLE;
      r_q       <= Q0;
      r_bit     <= '0;
      r_byte    <= '0;
      r_shift   <= '0;
      r_scl     <= 1'b1;
      r_sda_low <= 1'b0;
      r_end     <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (iGO && !r_end) begin
            r_shift <= iDATA;
            r_ack   <= 1'b0;
            r_q     <= Q0;
            r_state <= START;
          end
        end
        DONE: begin
          if (!iGO) begin
            r_end   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          if (w_tick) begin
            r_q <= r_q + 2'd1;
            case (r_state)
              START: begin
                unique case (r_q)
                  Q0: r_sda_low <= 1'b1;
                  Q1: r_scl <= 1'b0;
                  Q2: ;
                  Q3: begin
                    r_state   <= BIT;
                    r_byte    <= '0;
                    r_bit     <= 3'd7;
                    r_sda_low <= !r_shift[W-1];
                  end
                endcase
              end
              BIT: begin
                unique case (r_q)
                  Q0: r_scl <= 1'b1;
                  Q1: ;
                  Q2: r_scl <= 1'b0;
                  Q3: begin
                    r_shift <= r_shift << 1;
                    if (r_bit == 3'd0) begin
                      r_state   <= ACK;
                      r_sda_low <= 1'b0;
                    end else begin
                      r_bit     <= r_bit - 3'd1;
                      r_sda_low <= !r_shift[W-2];
                    end
                  end
                endcase
              end
              ACK: begin
                unique case (r_q)
                  Q0: r_scl <= 1'b1;
                  Q1: ;
                  // Sample at the end of the second high quarter.
                  Q2: begin
                    r_scl <= 1'b0;
                    if (w_sda_in) begin
                      r_ack <= 1'b1;
                    end
                  end
                  Q3: begin
                    if (r_ack || w_last_byte) begin
                      r_state   <= STOP;
                      r_sda_low <= 1'b1;
                    end else begin
                      r_state   <= BIT;
                      r_byte    <= r_byte + 1'b1;
                      r_bit     <= 3'd7;
                      r_sda_low <= !r_shift[W-1];
                    end
                  end
                endcase
              end
              STOP: begin
                unique case (r_q)
                  Q0: r_scl <= 1'b1;
                  Q1: r_sda_low <= 1'b0;
                  Q2: ;
                  Q3: begin
                    r_state <= DONE;
                    r_end   <= 1'b1;
                  end
                endcase
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_write_master.sv
// Directed bench for i2c_write_master with an I2C bus monitor
// and an ACKing slave model; fast divider plus a default-rate instance.
module tb_i2c_write_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [23:0] data;
  logic        end_o;
  logic        ack_o;
  logic        scl;
  wire         sda;
  logic        rst_d;
  logic        go_d;
  logic        end_d;
  logic        ack_d;
  logic        scl_d;
  wire         sda_d;
  logic        slv_low = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign sda = slv_low ? 1'b0 : 1'bz;
  pullup (sda);
  pullup (sda_d);

  i2c_write_master #(
    .CLK_FREQ  (400),
    .I2C_FREQ  (10),
    .NUM_BYTES (3)
  ) u_dut (
    .iCLK     (clk),
    .iRST     (rst),
    .iDATA    (data),
    .iGO      (go),
    .oEND     (end_o),
    .oACK     (ack_o),
    .I2C_SCLK (scl),
    .I2C_SDAT (sda)
  );

  i2c_write_master u_def (
    .iCLK     (clk),
    .iRST     (rst_d),
    .iDATA    (24'h340C00),
    .iGO      (go_d),
    .oEND     (end_d),
    .oACK     (ack_d),
    .I2C_SCLK (scl_d),
    .I2C_SDAT (sda_d)
  );

  // Bus monitor and slave model (single process owns all state).
  int         n_start = 0;
  int         n_stop = 0;
  int         bitn = 0;
  int         byten = 0;
  int         nack_byte = 99;
  logic [7:0] sh = 8'h00;
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;
  logic [7:0] q_byte[$];
  logic       q_ack[$];

  always @(scl or sda) begin
    if (scl !== p_scl) begin
      if (scl === 1'b1) begin
        if (bitn < 8) begin
          sh   = {sh[6:0], (sda === 1'b1)};
          bitn = bitn + 1;
        end else begin
          q_byte.push_back(sh);
          q_ack.push_back(sda === 1'b1);
          bitn  = 0;
          byten = byten + 1;
        end
      end else begin
        slv_low = (bitn == 8) && (byten != nack_byte);
      end
    end else if (sda !== p_sda && scl === 1'b1) begin
      if (sda === 1'b0) begin
        n_start = n_start + 1;
        bitn    = 0;
        byten   = 0;
      end else begin
        n_stop = n_stop + 1;
      end
    end
    p_scl = scl;
    p_sda = sda;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Raise iGO and return just after the accept edge.
  task automatic launch(input logic [23:0] d);
    @(negedge clk);
    data = d;
    go   = 1'b1;
    @(posedge clk);
  endtask

  task automatic wait_end(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!end_o && n < 5000);
  endtask

  int n;
  int s0;
  int p0;
  int b0;
  int r1;
  int r2;
  logic ps;
  logic [7:0] exp_b[3];

  initial begin
    rst   = 1'b1;
    go    = 1'b0;
    data  = '0;
    rst_d = 1'b1;
    go_d  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);
    check("rst_end", end_o, 0);
    check("rst_ack", ack_o, 0);
    check("rst_def_scl", scl_d, 1);
    check("rst_def_end", end_d, 0);
    check("rst_def_ack", ack_d, 0);
    @(negedge clk);
    rst   = 1'b0;
    rst_d = 1'b0;

    // Default divider: SDA falls after one quarter, SCL after two.
    @(negedge clk);
    go_d = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (sda_d !== 1'b0 && n < 2000);
    check("def_sda_fall", n, 625);
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (scl_d !== 1'b0 && n < 3000);
    check("def_scl_fall", n, 1250);
    @(negedge clk);
    rst_d = 1'b1;
    go_d  = 1'b0;

    // Nominal write; iDATA scrambled one clock after accept.
    s0 = n_start;
    p0 = n_stop;
    b0 = q_byte.size();
    launch(24'h340C00);
    n  = 0;
    r1 = 0;
    r2 = 0;
    ps = 1'b1;
    do begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) data = 24'hFFFFFF;
      if (scl && !ps) begin
        if (r1 == 0) r1 = n;
        else if (r2 == 0) r2 = n;
      end
      ps = scl;
    end while (!end_o && n < 5000);
    check("nom_len", n, 1160);
    check("nom_scl_rise1", r1, 50);
    check("nom_scl_period", r2 - r1, 40);
    check("nom_ack", ack_o, 0);
    check("nom_starts", n_start - s0, 1);
    check("nom_stops", n_stop - p0, 1);
    check("nom_nbytes", q_byte.size() - b0, 3);
    exp_b[0] = 8'h34;
    exp_b[1] = 8'h0C;
    exp_b[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("nom_byte%0d", i), q_byte[b0+i], exp_b[i]);
      check($sformatf("nom_ackbit%0d", i), q_ack[b0+i], 0);
    end

    // Handshake: holding iGO never retransmits.
    repeat (1000) @(posedge clk);
    #1;
    check("hs_end_held", end_o, 1);
    check("hs_no_restart", n_start - s0, 1);
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    #1;
    check("hs_end_drop", end_o, 0);

    // Restart with an address NACK.
    s0 = n_start;
    p0 = n_stop;
    b0 = q_byte.size();
    nack_byte = 0;
    launch(24'h40C301);
    wait_end(n);
    check("nack_len", n, 440);
    check("nack_ack", ack_o, 1);
    check("nack_starts", n_start - s0, 1);
    check("nack_stops", n_stop - p0, 1);
    check("nack_nbytes", q_byte.size() - b0, 1);
    check("nack_byte0", q_byte[b0], 8'h40);
    check("nack_ackbit", q_ack[b0], 1);

    // Reset during bit 4 of byte 1.
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    nack_byte = 99;
    launch(24'h340C00);
    repeat (523) @(posedge clk);
    #1;
    check("mid_pre_scl", scl, 0);
    check("mid_pre_sda", sda, 0);
    check("mid_pre_end", end_o, 0);
    @(negedge clk);
    rst = 1'b1;
    go  = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_scl", scl, 1);
    check("mid_rst_sda", sda, 1);
    check("mid_rst_end", end_o, 0);
    check("mid_rst_ack", ack_o, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_idle_scl", scl, 1);

    // Clean transfer after reset.
    s0 = n_start;
    b0 = q_byte.size();
    launch(24'h1A2B3C);
    wait_end(n);
    check("post_len", n, 1160);
    check("post_ack", ack_o, 0);
    check("post_starts", n_start - s0, 1);
    check("post_nbytes", q_byte.size() - b0, 3);
    exp_b[0] = 8'h1A;
    exp_b[1] = 8'h2B;
    exp_b[2] = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("post_byte%0d", i), q_byte[b0+i], exp_b[i]);
    end
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_write_master.md
Name: i2c_write_master

Overview:
- Serial I2C write engine that consumes the 24-bit {slave address, sub-address, data} words issued by the codec/video-decoder configuration sequencer.
- Drives the shared I2C bus, reports completion and acknowledge status back to the sequencer.
- Runs on the system clock with an internal clock-enable divider; no derived clock domain.
- Write-only, single master, no clock stretching, no reads.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- I2C_FREQ, 20000, SCL frequency in Hz; quarter-bit tick period DIV = CLK_FREQ/(4*I2C_FREQ) clocks (625 at defaults).
- NUM_BYTES, 3, bytes per transfer, sent MSB byte first.

Ports:
- iCLK  in  1  system clock; the block's only clock.
- iRST  in  1  synchronous, active-high reset.
- iDATA  in  8*NUM_BYTES  {slave_addr+W, sub_addr, data}; MSB bit first.
- iGO  in  1  level request, 4-phase handshake with oEND.
- oEND  out  1  transfer complete; held until iGO drops.
- oACK  out  1  1 = at least one slave NACK in the last transfer (failure); 0 = all bytes ACKed.
- I2C_SCLK  out  1  SCL, push-pull, idle high.
- I2C_SDAT  inout  1  SDA, open-drain: driven 0 or released (Z); bus pull-up assumed.

Behaviour:
- Reset (sync, iRST=1 at posedge): state IDLE, oEND=0, oACK=0, I2C_SCLK=1, SDA released, divider and bit/byte counters cleared. Applies mid-transfer too: the bus is released on the next cycle, no STOP is generated, and the slave is left to time out.
- Tick: counter 0..DIV-1, runs only when not IDLE, cleared on accept; tick asserted when count = DIV-1. All bus phase changes occur only on tick.
- States: IDLE, START, BIT, ACK, STOP, DONE.
- IDLE: when iGO=1 and oEND=0, latch iDATA into the shift register, clear oACK, go to START. Accept latency is 1 clock. iDATA changes after accept are ignored.
- START (4 ticks): q0 SCL1/SDA1, q1 SCL1/SDA0, q2 SCL0/SDA0, q3 SCL0/SDA0. Then go to BIT with byte=0, bit=7.
- BIT (4 ticks per bit):
  - q0: SCL0, SDA = shift MSB (0 → drive low, 1 → release).
  - q1: SCL1. q2: SCL1. q3: SCL0, shift left.
  - After bit 0, go to ACK.
- ACK (4 ticks): SDA released. q0 SCL0, q1 SCL1, q2 SCL1 with SDA sampled (1 → oACK<=1), q3 SCL0. Then:
  - If NACK, go to STOP; remaining bytes are skipped.
  - Else if byte < NUM_BYTES-1, byte++ and go to BIT.
  - Else go to STOP.
- STOP (4 ticks): q0 SCL0/SDA0, q1 SCL1/SDA0, q2 SCL1/SDA1 (released), q3 hold. Then go to DONE with oEND<=1.
- DONE: oEND=1 and oACK stable while iGO=1. When iGO=0, oEND<=0 and return to IDLE on the next clock.
- A new transfer requires iGO to drop and rise again; holding iGO high never retransmits. iGO changes while busy are ignored.
- Full transfer = 4 + NUM_BYTES*36 + 4 ticks (116 ticks = 72500 clocks at defaults). A NACK on byte k (0-based) gives 4 + (k+1)*36 + 4 ticks.
- SDA only changes while SCL=0, except the START/STOP edges.

Decomposition:
- Shared package i2c_pkg: state enum (IDLE, START, BIT, ACK, STOP, DONE), quarter-phase constants Q0..Q3, and the function computing DIV from CLK_FREQ/I2C_FREQ.
- Sub-module i2c_tick_gen(iCLK, iRST, iEN, oTICK): the clock-enable divider, DIV parameter, counter held at 0 when iEN=0.

Test Plan:
- Nominal write, iDATA=24'h340C00 with the slave model ACKing all bytes → bus shows START, bytes 0x34, 0x0C, 0x00 MSB first, 9th-bit ACK slots, STOP. oEND rises 116 ticks after accept; oACK=0.
- Address NACK (model releases SDA on the first ACK slot), iDATA=24'h40C301 → oACK=1, STOP right after byte 0, oEND at 44 ticks; bytes 0xC3 and 0x01 never appear.
- Handshake: iGO held high 1000 clocks after oEND → no second START, oEND stays 1. Drop iGO → oEND=0 one clock later. Raise iGO again → new START begins.
- Mid-transfer reset: assert iRST during bit 4 of byte 1 → next clock SCL=1, SDA=Z, oEND=0, oACK=0. The following iGO starts a clean transfer.
- Data stability: change iDATA to 24'hFFFFFF one clock after accept → transmitted bytes still match the latched value.
- Divider check with CLK_FREQ=400, I2C_FREQ=10 (DIV=10): SCL period measures exactly 40 clocks, and a full transfer takes 1160 clocks from accept to oEND.
